imem_fetch_buffer: RTL and testbench

Parametrised instruction memory with an integrated fetch engine, the next step beyond our single-cycle combinational instruction ROM. Holds a 2^ADDR_W-word synchronous-read array and walks a fetch PC on its own. Delivers instructions to the core through a valid/ready prefetch FIFO. Supports pipeline redirect (branch/jump flush) and a write port for program loading from the boot/debug path.

---
 rtl/imem_fetch_buffer.sv | 119 +++++++++++
 tb/tb_imem_fetch_buffer.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/imem_fetch_buffer.sv
// Instruction memory with self-walking fetch PC feeding a valid/ready prefetch FIFO.
// Latency: 2 edges from issue to head-of-FIFO; 1 instruction/cycle sustained.
// Backpressure: issue is credit-limited by (count + pending) so the FIFO never overflows.
module imem_fetch_buffer #(
  parameter int          ADDR_W     = 11,
  parameter int          DATA_W     = 32,
  parameter int          FIFO_DEPTH = 4,
  parameter logic [31:0] RESET_PC   = 32'h0040_0000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              redirect_valid,
  input  logic [31:0]       redirect_pc,
  input  logic              load_we,
  input  logic [ADDR_W-1:0] load_addr,
  input  logic [DATA_W-1:0] load_data,
  output logic              inst_valid,
  input  logic              inst_ready,
  output logic [DATA_W-1:0] inst_data,
  output logic [31:0]       inst_pc,
  output logic              busy
);

  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(FIFO_DEPTH);

  // Instruction array and its synchronous read register (neither is reset).
  logic [DATA_W-1:0] mem [0:(1<<ADDR_W)-1];
  logic [DATA_W-1:0] rd_data_q;

  // Prefetch FIFO storage; entries beyond count_q are don't-care.
  logic [DATA_W-1:0] fifo_dat [0:FIFO_DEPTH-1];
  logic [31:0]       fifo_pc  [0:FIFO_DEPTH-1];

  logic [31:0]      fpc_q, fpc_d;
  logic [31:0]      rd_pc_q, rd_pc_d;
  logic             pend_q, pend_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [PTR_W-1:0] wptr_q, wptr_d;
  logic [PTR_W-1:0] rptr_q, rptr_d;

  logic             issue, push, pop;
  logic [CNT_W-1:0] credit;
  logic [ADDR_W-1:0] rd_idx;

  assign rd_idx     = fpc_q[ADDR_W+1:2];
  assign inst_valid = (count_q != '0);
  assign inst_data  = inst_valid ? fifo_dat[rptr_q] : '0;
  assign inst_pc    = inst_valid ? fifo_pc[rptr_q] : '0;
  assign busy       = load_we || ((count_q == '0) && pend_q);

  // Issue/push/pop decisions; redirect overrides the FIFO traffic of its cycle.
  always_comb begin
    credit = count_q + CNT_W'(pend_q);
    issue  = (credit < DEPTH_C) && !load_we && !redirect_valid;
    push   = pend_q && !redirect_valid;
    pop    = inst_valid && inst_ready && !redirect_valid;
  end

  // Next-state for fetch PC, pending read and FIFO pointers.
  always_comb begin
    fpc_d   = fpc_q;
    rd_pc_d = rd_pc_q;
    pend_d  = issue;
    count_d = count_q + CNT_W'(push) - CNT_W'(pop);
    wptr_d  = push ? wptr_q + 1'b1 : wptr_q;
    rptr_d  = pop ? rptr_q + 1'b1 : rptr_q;
    if (issue) begin
      rd_pc_d = fpc_q;
      fpc_d   = fpc_q + 32'd4;
    end
    if (redirect_valid) begin
      fpc_d   = redirect_pc;
      pend_d  = 1'b0;
      count_d = '0;
      wptr_d  = '0;
      rptr_d  = '0;
    end
  end

  // Control state registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fpc_q   <= RESET_PC;
      rd_pc_q <= '0;
      pend_q  <= 1'b0;
      count_q <= '0;
      wptr_q  <= '0;
      rptr_q  <= '0;
    end else begin
      fpc_q   <= fpc_d;
      rd_pc_q <= rd_pc_d;
      pend_q  <= pend_d;
      count_q <= count_d;
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
    end
  end

  // Program-load write port.
  always_ff @(posedge clk) begin
    if (load_we) mem[load_addr] <= load_data;
  end

  // Synchronous read port, only clocked on issue (never coincides with a load).
  always_ff @(posedge clk) begin
    if (issue) rd_data_q <= mem[rd_idx];
  end

  // Push the captured word and its PC into the FIFO tail.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_dat[wptr_q] <= rd_data_q;
      fifo_pc[wptr_q]  <= rd_pc_q;
    end
  end

endmodule

// File: tb/tb_imem_fetch_buffer.sv
module tb_imem_fetch_buffer;

  localparam int          AW    = 11;
  localparam int          DEPTH = 4;
  localparam logic [31:0] RPC   = 32'h0040_0000;

  logic          clk = 1'b0;
  logic          rst;
  logic          redirect_valid;
  logic [31:0]   redirect_pc;
  logic          load_we;
  logic [AW-1:0] load_addr;
  logic [31:0]   load_data;
  logic          inst_valid;
  logic          inst_ready;
  logic [31:0]   inst_data;
  logic [31:0]   inst_pc;
  logic          busy;

  imem_fetch_buffer #(.ADDR_W(AW), .DATA_W(32), .FIFO_DEPTH(DEPTH), .RESET_PC(RPC)) dut (
    .clk(clk), .rst(rst),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .load_we(load_we), .load_addr(load_addr), .load_data(load_data),
    .inst_valid(inst_valid), .inst_ready(inst_ready),
    .inst_data(inst_data), .inst_pc(inst_pc), .busy(busy)
  );

  always #5 clk = ~clk;

  // Reference model: memory image, prefetch queue, one outstanding read, fetch PC.
  logic [31:0] m_mem [0:(1<<AW)-1];
  logic [31:0] q_pc[$];
  logic [31:0] q_dat[$];
  bit          m_pend;
  logic [31:0] m_ppc, m_pdat, m_fpc;

  // Words actually accepted from the DUT, with the step index of acceptance.
  logic [31:0] got_pc[$];
  logic [31:0] got_dat[$];
  int          got_cyc[$];
  int          cyc = 0;

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $display("FAIL %s: observed %h expected %h", tag, obs, exp);
      $error("mismatch in %s", tag);
    end
  endtask

  task automatic m_reset();
    q_pc.delete();
    q_dat.delete();
    m_pend = 0;
    m_fpc  = RPC;
  endtask

  task automatic clr_got();
    got_pc.delete();
    got_dat.delete();
    got_cyc.delete();
  endtask

  // One clock cycle: drive, check outputs against the model, clock, advance the model.
  task automatic step(input bit rv, input logic [31:0] rpc, input bit we,
                      input logic [AW-1:0] la, input logic [31:0] ld, input bit rdy);
    bit iss;
    bit pop;
    redirect_valid = rv;
    redirect_pc    = rpc;
    load_we        = we;
    load_addr      = la;
    load_data      = ld;
    inst_ready     = rdy;
    #1;
    chk("valid", 32'(inst_valid), 32'(q_pc.size() != 0));
    chk("data",  inst_data, (q_pc.size() != 0) ? q_dat[0] : 32'h0);
    chk("pc",    inst_pc,   (q_pc.size() != 0) ? q_pc[0]  : 32'h0);
    chk("busy",  32'(busy), 32'(we || (q_pc.size() == 0 && m_pend)));
    pop = rdy && (q_pc.size() != 0) && !rv && !rst;
    if (pop) begin
      got_pc.push_back(inst_pc);
      got_dat.push_back(inst_data);
      got_cyc.push_back(cyc);
    end
    iss = ((q_pc.size() + int'(m_pend)) < DEPTH) && !we && !rv;
    @(posedge clk);
    if (rst) begin
      m_reset();
    end else if (rv) begin
      q_pc.delete();
      q_dat.delete();
      m_pend = 0;
      m_fpc  = rpc;
    end else begin
      if (pop) begin
        void'(q_pc.pop_front());
        void'(q_dat.pop_front());
      end
      if (m_pend) begin
        q_pc.push_back(m_ppc);
        q_dat.push_back(m_pdat);
      end
      m_pend = iss;
      if (iss) begin
        m_ppc  = m_fpc;
        m_pdat = m_mem[m_fpc[AW+1:2]];
        m_fpc  = m_fpc + 32'd4;
      end
    end
    if (we) m_mem[la] = ld;
    cyc++;
    @(negedge clk);
  endtask

  task automatic idle(input bit rdy);
    step(1'b0, 32'h0, 1'b0, '0, 32'h0, rdy);
  endtask

  task automatic redir(input logic [31:0] pc, input bit rdy);
    step(1'b1, pc, 1'b0, '0, 32'h0, rdy);
  endtask

  task automatic chk_got(input string tag, input int k, input logic [31:0] pc, input logic [31:0] dat);
    if (got_pc.size() <= k) begin
      chk({tag, "_count"}, 32'(got_pc.size()), 32'(k + 1));
      return;
    end
    chk({tag, "_pc"},  got_pc[k],  pc);
    chk({tag, "_dat"}, got_dat[k], dat);
  endtask

  initial begin
    int c0;
    logic [31:0] w;
    rst = 1'b1;
    redirect_valid = 1'b0; redirect_pc = '0; load_we = 1'b0;
    load_addr = '0; load_data = '0; inst_ready = 1'b0;
    m_reset();
    @(negedge clk);
    #1;
    chk("rst_valid", 32'(inst_valid), 32'h0);
    chk("rst_data",  inst_data, 32'h0);
    chk("rst_pc",    inst_pc,   32'h0);
    chk("rst_busy",  32'(busy), 32'h0);
    @(negedge clk);

    // Program image loaded while held in reset.
    for (int i = 0; i < (1 << AW); i++) begin
      w = (i < 8) ? 32'h1000_0000 + 32'(i) : $urandom;
      step(1'b0, 32'h0, 1'b1, AW'(i), w, 1'b0);
    end
    rst = 1'b0;

    // 1: redirect to 0, consumer always ready.
    clr_got();
    c0 = cyc;
    redir(32'h0, 1'b1);
    repeat (12) idle(1'b1);
    if (got_cyc.size() > 0) chk("t1_first_cycle", 32'(got_cyc[0]), 32'(c0 + 3));
    for (int k = 0; k < 8; k++) chk_got("t1", k, 32'(4 * k), 32'h1000_0000 + 32'(k));
    if (got_cyc.size() > 7) chk("t1_no_gap", 32'(got_cyc[7] - got_cyc[0]), 32'd7);

    // 2: stalled consumer saturates the FIFO, then drains in order with no gap.
    redir(32'h0, 1'b0);
    repeat (10) idle(1'b0);
    clr_got();
    c0 = cyc;
    repeat (8) idle(1'b1);
    for (int k = 0; k < 5; k++) begin
      chk_got("t2", k, 32'(4 * k), 32'h1000_0000 + 32'(k));
      if (got_cyc.size() > k) chk("t2_cycle", 32'(got_cyc[k]), 32'(c0 + k));
    end

    // 3: redirect while FIFO holds 3 and a read is pending, with a same-cycle pop.
    redir(32'h0, 1'b0);
    for (int i = 0; i < 10 && !(q_pc.size() == 3 && m_pend); i++) idle(1'b0);
    chk("t3_valid_before", 32'(inst_valid), 32'h1);
    clr_got();
    redir(32'h20, 1'b1);
    repeat (6) idle(1'b1);
    for (int k = 0; k < 3; k++) chk_got("t3", k, 32'h20 + 32'(4 * k), m_mem[8 + k]);

    // 4: 3-cycle load while streaming, then redirect to fetch the new word.
    redir(32'h0, 1'b1);
    repeat (5) idle(1'b1);
    repeat (3) begin
      step(1'b0, 32'h0, 1'b1, AW'(2), 32'hDEAD_BEEF, 1'b1);
      chk("t4_busy_after", 32'(busy), 32'h1);
    end
    clr_got();
    redir(32'h8, 1'b1);
    repeat (5) idle(1'b1);
    chk_got("t4", 0, 32'h8, 32'hDEAD_BEEF);
    chk_got("t4", 1, 32'hC, 32'h1000_0003);

    // 5: wrap past the last word of the array.
    clr_got();
    redir(32'h1FFC, 1'b1);
    repeat (6) idle(1'b1);
    chk_got("t5", 0, 32'h1FFC, m_mem[(1 << AW) - 1]);
    chk_got("t5", 1, 32'h2000, 32'h1000_0000);
    chk_got("t5", 2, 32'h2004, 32'h1000_0001);

    // 6: asynchronous reset mid-stream with 3 entries buffered.
    redir(32'h0, 1'b0);
    for (int i = 0; i < 10 && q_pc.size() != 3; i++) idle(1'b0);
    chk("t6_valid_before", 32'(inst_valid), 32'h1);
    #2 rst = 1'b1;
    #1;
    chk("t6_async_valid", 32'(inst_valid), 32'h0);
    chk("t6_async_data",  inst_data, 32'h0);
    chk("t6_async_pc",    inst_pc,   32'h0);
    m_reset();
    @(negedge clk);
    idle(1'b0);
    rst = 1'b0;
    clr_got();
    repeat (6) idle(1'b1);
    chk_got("t6", 0, RPC, m_mem[0]);
    chk_got("t6", 1, RPC + 32'd4, m_mem[1]);

    // Random traffic against the model.
    for (int i = 0; i < 800; i++) begin
      int r;
      bit rdy;
      r   = int'($urandom_range(0, 99));
      rdy = ($urandom_range(0, 3) != 0);
      if (r < 5) begin
        w = ($urandom_range(0, 1) != 0) ? ($urandom & 32'h0000_1FFF) : $urandom;
        step(1'b1, w, ($urandom_range(0, 3) == 0), AW'($urandom), $urandom, rdy);
      end else if (r < 12) begin
        step(1'b0, 32'h0, 1'b1, AW'($urandom), $urandom, rdy);
      end else begin
        idle(rdy);
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
